// File: rtl/ped_request_ctrl.sv
// ---------------------------------------------------------------------------
// ped_request_ctrl
//
// Turns the debounced pedestrian push-button pulse into a latched crossing
// request for the traffic-light FSM, follows the req/ack handshake through
// the walk phase, enforces a hold-off window after each walk phase and
// drives the blinking WAIT indicator.
//
// Parameters
//   BLINK_DIV    cycles per wait_led toggle while a request is pending
//   HOLDOFF_CYC  cycles spent in hold-off after a walk phase ends (>= 2)
//
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous, active-low reset
//   press_pulse   in   one-cycle pulse per debounced button press
//   ped_ack       in   one-cycle pulse: request accepted, walk scheduled
//   walk_active   in   level, high during the walk phase
//   ped_req       out  level, pedestrian request pending
//   wait_led      out  WAIT indicator (blinks while pending)
//   press_cnt     out  presses received while pending, saturating at 3
//   served_pulse  out  one-cycle pulse when a walk phase completes
//   ped_urgent    out  pending with press_cnt==3 (only with PED_URGENT_EN)
//
// Build option
//   PED_URGENT_EN  when defined, ped_urgent is driven; otherwise it is tied
//                  low and no logic is generated for it.
// ---------------------------------------------------------------------------
module ped_request_ctrl #(
  parameter int BLINK_DIV   = 12_500_000,
  parameter int HOLDOFF_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       press_pulse,
  input  logic       ped_ack,
  input  logic       walk_active,
  output logic       ped_req,
  output logic       wait_led,
  output logic [1:0] press_cnt,
  output logic       served_pulse,
  output logic       ped_urgent
);

  // A divider of 1 would give a zero-width counter; keep at least one bit.
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HOLD_W  = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF_CYC - 1);

  if (HOLDOFF_CYC < 2) begin : g_bad_holdoff
    $error("ped_request_ctrl: HOLDOFF_CYC must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVING = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t             state_q,        state_d;
  logic               ped_req_q,      ped_req_d;
  logic               wait_led_q,     wait_led_d;
  logic [1:0]         press_cnt_q,    press_cnt_d;
  logic               served_pulse_q, served_pulse_d;
  logic               walk_prev_q,    walk_prev_d;
  logic               holdoff_pend_q, holdoff_pend_d;
  logic [BLINK_W-1:0] blink_cnt_q,    blink_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q,     hold_cnt_d;

  // Press counter increment that sticks at 3 instead of wrapping.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  always_comb begin
    state_d        = state_q;
    ped_req_d      = ped_req_q;
    wait_led_d     = wait_led_q;
    press_cnt_d    = press_cnt_q;
    served_pulse_d = 1'b0;
    walk_prev_d    = walk_active;
    holdoff_pend_d = holdoff_pend_q;
    blink_cnt_d    = blink_cnt_q;
    hold_cnt_d     = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        ped_req_d      = 1'b0;
        wait_led_d     = 1'b0;
        press_cnt_d    = 2'd0;
        blink_cnt_d    = '0;
        hold_cnt_d     = '0;
        holdoff_pend_d = 1'b0;
        if (press_pulse) begin
          state_d     = ST_PENDING;
          ped_req_d   = 1'b1;
          wait_led_d  = 1'b1;
          press_cnt_d = 2'd1;
        end
      end

      ST_PENDING: begin
        // Acknowledge takes priority; a press in the same cycle is dropped.
        if (ped_ack) begin
          state_d     = ST_SERVING;
          ped_req_d   = 1'b0;
          wait_led_d  = 1'b0;
          press_cnt_d = 2'd0;
          blink_cnt_d = '0;
        end else begin
          ped_req_d = 1'b1;
          if (press_pulse) begin
            press_cnt_d = sat_inc2(press_cnt_q);
          end
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            wait_led_d  = ~wait_led_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end

      ST_SERVING: begin
        // Walk phase is over on the falling edge of walk_active.
        if (walk_prev_q && !walk_active) begin
          state_d        = ST_HOLDOFF;
          served_pulse_d = 1'b1;
          hold_cnt_d     = '0;
          holdoff_pend_d = 1'b0;
        end
      end

      ST_HOLDOFF: begin
        if (press_pulse) begin
          holdoff_pend_d = 1'b1;
        end
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d     = '0;
          holdoff_pend_d = 1'b0;
          // A press in the terminal cycle itself still counts.
          if (holdoff_pend_q || press_pulse) begin
            state_d     = ST_PENDING;
            ped_req_d   = 1'b1;
            wait_led_d  = 1'b1;
            press_cnt_d = 2'd1;
            blink_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d        = ST_IDLE;
        ped_req_d      = 1'b0;
        wait_led_d     = 1'b0;
        press_cnt_d    = 2'd0;
        blink_cnt_d    = '0;
        hold_cnt_d     = '0;
        holdoff_pend_d = 1'b0;
      end
    endcase
  end

`ifdef PED_URGENT_EN
  logic ped_urgent_q, ped_urgent_d;

  // Derived from next-state values so it drops on the same edge as ped_ack.
  assign ped_urgent_d = (state_d == ST_PENDING) && (press_cnt_d == 2'd3);
  assign ped_urgent   = ped_urgent_q;
`else
  assign ped_urgent = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      ped_req_q      <= 1'b0;
      wait_led_q     <= 1'b0;
      press_cnt_q    <= 2'd0;
      served_pulse_q <= 1'b0;
      walk_prev_q    <= 1'b0;
      holdoff_pend_q <= 1'b0;
      blink_cnt_q    <= '0;
      hold_cnt_q     <= '0;
`ifdef PED_URGENT_EN
      ped_urgent_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ped_req_q      <= ped_req_d;
      wait_led_q     <= wait_led_d;
      press_cnt_q    <= press_cnt_d;
      served_pulse_q <= served_pulse_d;
      walk_prev_q    <= walk_prev_d;
      holdoff_pend_q <= holdoff_pend_d;
      blink_cnt_q    <= blink_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
`ifdef PED_URGENT_EN
      ped_urgent_q   <= ped_urgent_d;
`endif
    end
  end

  assign ped_req      = ped_req_q;
  assign wait_led     = wait_led_q;
  assign press_cnt    = press_cnt_q;
  assign served_pulse = served_pulse_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ped_request_ctrl
//
// Scenario bench for ped_request_ctrl with BLINK_DIV=4, HOLDOFF_CYC=8.
// Each cycle the expected output vector is queued when the stimulus is
// driven and popped for comparison one time unit after the clock edge.
// Output vector layout: {ped_req, wait_led, press_cnt[1:0], served, urgent}.
// ---------------------------------------------------------------------------
module tb_ped_request_ctrl;

  localparam int BLINK_DIV   = 4;
  localparam int HOLDOFF_CYC = 8;

`ifdef PED_URGENT_EN
  localparam bit URG_EN = 1'b1;
`else
  localparam bit URG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       press_pulse = 1'b0;
  logic       ped_ack = 1'b0;
  logic       walk_active = 1'b0;
  logic       ped_req;
  logic       wait_led;
  logic [1:0] press_cnt;
  logic       served_pulse;
  logic       ped_urgent;
  logic [5:0] obs;

  typedef struct {
    string      name;
    logic [5:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         errors = 0;
  int         checks = 0;
  int         pend_k = 0;
  logic [1:0] exp_cnt;

  ped_request_ctrl #(
    .BLINK_DIV   (BLINK_DIV),
    .HOLDOFF_CYC (HOLDOFF_CYC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .press_pulse  (press_pulse),
    .ped_ack      (ped_ack),
    .walk_active  (walk_active),
    .ped_req      (ped_req),
    .wait_led     (wait_led),
    .press_cnt    (press_cnt),
    .served_pulse (served_pulse),
    .ped_urgent   (ped_urgent)
  );

  assign obs = {ped_req, wait_led, press_cnt, served_pulse, ped_urgent};

  always #5 clk = ~clk;

  function automatic logic [5:0] mk(input bit req, input bit led,
                                    input logic [1:0] cnt, input bit srv,
                                    input bit urg);
    return {req, led, cnt, srv, urg};
  endfunction

  // Expected WAIT level k edges after entering PENDING (starts lit).
  function automatic bit led_at(input int k);
    return ((k / BLINK_DIV) % 2) == 0;
  endfunction

  task automatic tick(input bit p, input bit a, input bit w);
    press_pulse = p;
    ped_ack     = a;
    walk_active = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{"reset_hold", mk(0, 0, 2'd0, 0, 0)});
      tick(1, 1, 1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.val);
      end
    end
    reset_n = 1'b1;
    // ack and a full walk pulse in IDLE must do nothing
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{"idle_ignore", mk(0, 0, 2'd0, 0, 0)});
      tick(0, (i % 2) == 1, i < 3);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_press_blink();
    pend_k = 0;
    exp_q.push_back('{"press_enter", mk(1, 1, 2'd1, 0, 0)});
    tick(1, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e.val) begin
      errors++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.val);
    end
    for (int k = 1; k <= 12; k++) begin
      pend_k = k;
      exp_q.push_back('{"blink", mk(1, led_at(k), 2'd1, 0, 0)});
      tick(0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got %b want %b", e.name, k, obs, e.val);
      end
    end
  endtask

  task automatic test_saturate();
    exp_cnt = 2'd1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4 && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      pend_k++;
      exp_q.push_back('{"saturate", mk(1, led_at(pend_k), exp_cnt, 0,
                                       URG_EN && (exp_cnt == 2'd3))});
      tick(i < 4, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s i=%0d: got %b want %b", e.name, i, obs, e.val);
      end
    end
  endtask

  task automatic test_ack_press();
    exp_q.push_back('{"ack_wins", mk(0, 0, 2'd0, 0, 0)});
    tick(1, 1, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e.val) begin
      errors++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.val);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{"serving_ignore", mk(0, 0, 2'd0, 0, 0)});
      tick(1, i == 2, 0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.val);
      end
    end
  endtask

  task automatic test_walk_served();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back('{"walk_high", mk(0, 0, 2'd0, 0, 0)});
      else       exp_q.push_back('{"served", mk(0, 0, 2'd0, 1, 0)});
      tick(0, 0, i < 5);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.val);
      end
    end
    for (int i = 1; i <= HOLDOFF_CYC; i++) begin
      exp_q.push_back('{"holdoff_quiet", mk(0, 0, 2'd0, 0, 0)});
      tick(0, i == 4, 0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s i=%0d: got %b want %b", e.name, i, obs, e.val);
      end
    end
    pend_k = 0;
    exp_q.push_back('{"idle_after_holdoff", mk(1, 1, 2'd1, 0, 0)});
    tick(1, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e.val) begin
      errors++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.val);
    end
  endtask

  // Ack from PENDING, short walk, then a hold-off with presses on the given
  // hold-off cycles; the request must reappear exactly at expiry.
  task automatic test_holdoff_press(input int p1, input int p2, input string tag);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) exp_q.push_back('{"to_holdoff", mk(0, 0, 2'd0, 0, 0)});
      else       exp_q.push_back('{"to_holdoff_served", mk(0, 0, 2'd0, 1, 0)});
      tick(0, i == 0, (i == 1) || (i == 2));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.val);
      end
    end
    for (int i = 1; i <= HOLDOFF_CYC; i++) begin
      if (i < HOLDOFF_CYC) exp_q.push_back('{tag, mk(0, 0, 2'd0, 0, 0)});
      else                 exp_q.push_back('{tag, mk(1, 1, 2'd1, 0, 0)});
      tick((i == p1) || (i == p2), 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s i=%0d: got %b want %b", e.name, i, obs, e.val);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      pend_k = k;
      exp_q.push_back('{"reblink", mk(1, led_at(k), 2'd1, 0, 0)});
      tick(0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got %b want %b", e.name, k, obs, e.val);
      end
    end
  endtask

  task automatic test_async_reset();
    pend_k++;
    exp_q.push_back('{"pre_reset_cnt2", mk(1, led_at(pend_k), 2'd2, 0, 0)});
    tick(1, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e.val) begin
      errors++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.val);
    end
    // Assert reset between edges; outputs must clear without a clock.
    #2;
    exp_q.push_back('{"async_reset", mk(0, 0, 2'd0, 0, 0)});
    reset_n = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e.val) begin
      errors++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.val);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{"post_reset_ack", mk(0, 0, 2'd0, 0, 0)});
      tick(0, 1, i < 2);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.val);
      end
    end
    exp_q.push_back('{"post_reset_press", mk(1, 1, 2'd1, 0, 0)});
    tick(1, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e.val) begin
      errors++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.val);
    end
    tick(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_press_blink();
    test_saturate();
    test_ack_press();
    test_walk_served();
    test_holdoff_press(3, 5, "holdoff_mid_press");
    test_holdoff_press(HOLDOFF_CYC, 0, "holdoff_last_press");
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
